down_count_monitor: RTL and testbench

- Sequence checker and wrap detector that sits directly downstream of the 4-bit synchronous down counter and samples its Q output every enabled clock.
- Checks that each sample equals the previous sample minus one, modulo 2^WIDTH.
- Emits a borrow pulse on every valid wrap from 0 to all-ones, keeps a saturating wrap count, and reports lock and sticky sequence-error status to downstream logic.

---
 rtl/down_count_monitor_if.sv | 25 ++
 rtl/down_count_monitor.sv | 105 ++++++++++
 tb/tb_down_count_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/down_count_monitor_if.sv
// Bus between a down counter's consumer and the sequence monitor: sample strobe,
// count value and clear in; borrow/wrap/lock/error status out.
interface down_count_monitor_if #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
);
   logic              en;
   logic [WIDTH-1:0]  count_in;
   logic              clr;
   logic              borrow_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic              locked;
   logic              seq_err;
   logic              err_pulse;

   modport master (
      output en, count_in, clr,
      input  borrow_pulse, wrap_count, locked, seq_err, err_pulse
   );

   modport slave (
      input  en, count_in, clr,
      output borrow_pulse, wrap_count, locked, seq_err, err_pulse
   );
endinterface

// File: rtl/down_count_monitor.sv
// Checks that a sampled down-count decrements by one each enabled clock, locks
// after LOCK_COUNT good steps, and flags wraps (0 -> all-ones) and lost sequence.
module down_count_monitor #(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 4,
   parameter int WRAP_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   down_count_monitor_if.slave  bus
);
   localparam int GR_W = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {INIT, ACQUIRE, LOCKED, FAULT} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [GR_W-1:0]   good_run_q, good_run_d;
   logic              borrow_q, borrow_d;
   logic              err_q, err_d;
   logic              seq_err_q, seq_err_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              match;

   assign match = (bus.count_in == (prev_q - WIDTH'(1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= INIT;
         prev_q     <= '0;
         good_run_q <= '0;
         borrow_q   <= 1'b0;
         err_q      <= 1'b0;
         seq_err_q  <= 1'b0;
         wrap_q     <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         good_run_q <= good_run_d;
         borrow_q   <= borrow_d;
         err_q      <= err_d;
         seq_err_q  <= seq_err_d;
         wrap_q     <= wrap_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      good_run_d = good_run_q;
      borrow_d   = 1'b0;
      err_d      = 1'b0;
      seq_err_d  = seq_err_q;
      wrap_d     = wrap_q;

      if (bus.en) begin
         prev_d = bus.count_in;
         unique case (state_q)
            // INIT and FAULT both take this sample purely as the new reference
            INIT, FAULT: begin
               state_d    = ACQUIRE;
               good_run_d = '0;
            end
            ACQUIRE: begin
               if (match) begin
                  borrow_d = (prev_q == '0);
                  if (good_run_q == GR_W'(LOCK_COUNT - 1)) begin
                     state_d    = LOCKED;
                     good_run_d = GR_W'(LOCK_COUNT);
                  end else begin
                     good_run_d = good_run_q + GR_W'(1);
                  end
               end else begin
                  good_run_d = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  borrow_d = (prev_q == '0);
               end else begin
                  state_d   = FAULT;
                  err_d     = 1'b1;
                  seq_err_d = 1'b1;
               end
            end
            default: state_d = INIT;
         endcase
      end

      if (borrow_d && (wrap_q != '1))
         wrap_d = wrap_q + WRAP_W'(1);

      // clear beats a same-cycle borrow or error; err_pulse is left to fire
      if (bus.clr) begin
         wrap_d    = '0;
         seq_err_d = 1'b0;
      end
   end

   assign bus.borrow_pulse = borrow_q;
   assign bus.wrap_count   = wrap_q;
   assign bus.locked       = (state_q == LOCKED);
   assign bus.seq_err      = seq_err_q;
   assign bus.err_pulse    = err_q;
endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor: acquisition, lock, fault, wrap
// saturation, clear priority, enable gating and asynchronous reset.
module tb_down_count_monitor;
   localparam int WIDTH = 4;
   localparam int LOCKN = 4;
   localparam int WRAPW = 4;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_err;
   logic [WIDTH-1:0] cur;
   int   nb;
   int   obs_b;

   down_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAPW)) bus ();

   down_count_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LOCKN), .WRAP_W(WRAPW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // present inputs, take one edge, settle 1ns past it
   task automatic step(input logic e, input logic [WIDTH-1:0] c, input logic cl);
      bus.en       = e;
      bus.count_in = c;
      bus.clr      = cl;
      @(posedge clk);
      #1;
      if (e) cur = c;
   endtask

   task automatic chk_all(input string tag, input logic b, input logic [31:0] w,
                          input logic l, input logic s, input logic ep);
      chk({tag, ".borrow"}, bus.borrow_pulse, b);
      chk({tag, ".wrap"},   bus.wrap_count,   w);
      chk({tag, ".locked"}, bus.locked,       l);
      chk({tag, ".seq_err"}, bus.seq_err,     s);
      chk({tag, ".err"},    bus.err_pulse,    ep);
   endtask

   initial begin
      n_chk = 0; n_err = 0; cur = '0;
      bus.en = 1'b0; bus.count_in = '0; bus.clr = 1'b0;
      reset_n = 1'b0;
      #2;
      chk_all("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: real counter sequence through a wrap into lock
      step(1, 4'd0, 0);  chk_all("t1.s0",  0, 0, 0, 0, 0);
      step(1, 4'd15, 0); chk_all("t1.s15", 1, 1, 0, 0, 0);
      step(1, 4'd14, 0); chk_all("t1.s14", 0, 1, 0, 0, 0);
      step(1, 4'd13, 0); chk("t1.s13.locked", bus.locked, 0);
      step(1, 4'd12, 0); chk_all("t1.s12", 0, 1, 1, 0, 0);
      step(1, 4'd11, 0); chk_all("t1.s11", 0, 1, 1, 0, 0);

      // 2: inject 7 where 10 expected, then recover
      step(1, 4'd7, 0);  chk_all("t2.bad", 0, 1, 0, 1, 1);
      step(1, 4'd6, 0);  chk_all("t2.ref", 0, 1, 0, 1, 0);
      step(1, 4'd5, 0);
      step(1, 4'd4, 0);
      step(1, 4'd3, 0);  chk("t2.s3.locked", bus.locked, 0);
      step(1, 4'd2, 0);  chk_all("t2.s2", 0, 1, 1, 1, 0);

      // 3: 40 wraps saturate a 4-bit wrap counter
      nb = 0; obs_b = 0;
      for (int i = 0; i < 640; i++) begin
         step(1, cur - 4'd1, 0);
         if (cur == 4'd15) nb++;
         if (bus.borrow_pulse) obs_b++;
      end
      chk("t3.borrows", obs_b, nb);
      chk("t3.nb40", nb, 40);
      chk("t3.sat", bus.wrap_count, 15);
      while (cur != 4'd0) step(1, cur - 4'd1, 0);
      chk("t3.seq_held", bus.seq_err, 1);
      step(1, 4'd15, 1); chk_all("t3.clr_borrow", 1, 0, 1, 0, 0);

      // 4: enable gating; stale values on en=0 cycles are ignored
      step(1, 4'd14, 0); chk_all("t4.a", 0, 0, 1, 0, 0);
      step(0, 4'd3, 0);  chk_all("t4.b", 0, 0, 1, 0, 0);
      step(1, 4'd13, 0); chk_all("t4.c", 0, 0, 1, 0, 0);
      step(0, 4'd12, 0); chk_all("t4.d", 0, 0, 1, 0, 0);
      step(1, 4'd12, 0); chk_all("t4.e", 0, 0, 1, 0, 0);
      while (cur != 4'd0) step(1, cur - 4'd1, 0);
      step(0, 4'd15, 0); chk_all("t4.gated_borrow", 0, 0, 1, 0, 0);
      step(1, 4'd15, 0); chk_all("t4.borrow", 1, 1, 1, 0, 0);
      step(1, 4'd7, 1);  chk_all("t4.clr_err", 0, 0, 0, 0, 1);

      // 5: five wraps, then asynchronous reset mid-cycle
      nb = 0;
      while (nb < 5) begin
         step(1, cur - 4'd1, 0);
         if (cur == 4'd15) nb++;
      end
      chk("t5.wrap5", bus.wrap_count, 5);
      chk("t5.locked", bus.locked, 1);
      #2 reset_n = 1'b0;
      #1;
      chk_all("t5.async", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 4'd9, 0);
      step(1, 4'd8, 0);
      step(1, 4'd7, 0);
      step(1, 4'd6, 0); chk("t5.s6.locked", bus.locked, 0);
      step(1, 4'd5, 0); chk_all("t5.relock", 0, 0, 1, 0, 0);

      // 6: up-count during acquisition never locks or errors
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      step(1, 4'd3, 0);
      step(1, 4'd4, 0); chk_all("t6.s4", 0, 0, 0, 0, 0);
      step(1, 4'd5, 0); chk_all("t6.s5", 0, 0, 0, 0, 0);
      step(1, 4'd6, 0); chk_all("t6.s6", 0, 0, 0, 0, 0);
      step(1, 4'd5, 0);
      step(1, 4'd4, 0);
      step(1, 4'd3, 0); chk("t6.s3.locked", bus.locked, 0);
      step(1, 4'd2, 0); chk("t6.s2.locked", bus.locked, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
